// File: rtl/prewish_mask_player.sv
// prewish_mask_player: strobe-fed mask FIFO that plays 8-bit blink masks MSB-first on one LED
module prewish_mask_player #(
  parameter int SYSCLK_DIV_BITS = 21,
  parameter int FIFO_AW = 2
) (
  input  logic               CLK_I,
  input  logic               RST_I,
  input  logic               STB_I,
  input  logic [7:0]         DAT_I,
  output logic               ACK_O,
  output logic               o_ovf,
  output logic [FIFO_AW:0]   o_level,
  output logic               o_busy,
  output logic               o_led,
  output logic               o_alive
);
  localparam int DEPTH = 2**FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LEVEL = DEPTH[FIFO_AW:0];
  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;
  state_t r_state, w_next;
  logic [7:0] r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wptr, r_rptr;
  logic [FIFO_AW:0] r_level;
  logic r_stb_last, r_ack, r_ovf;
  logic [7:0] r_shreg, r_held;
  logic [2:0] r_bitcnt;
  logic [SYSCLK_DIV_BITS-1:0] r_timer;
  logic w_edge, w_full, w_push, w_pop, w_has, w_tick, w_last;
  assign w_edge = STB_I & ~r_stb_last;
  assign w_full = r_level == FULL_LEVEL;
  assign w_push = w_edge & ~w_full;
  assign w_pop = r_state == LOAD;
  assign w_has = r_level != '0;
  assign w_tick = &r_timer;
  assign w_last = r_bitcnt == 3'd7;
  assign ACK_O = r_ack;
  assign o_ovf = r_ovf;
  assign o_level = r_level;
  assign o_busy = r_state != IDLE;
  assign o_led = (r_state == PLAY) & r_shreg[7];
  assign o_alive = r_timer[SYSCLK_DIV_BITS-1];
  // Mask storage; contents are don't-care until written, so no reset.
  always_ff @(posedge CLK_I) begin
    if (w_push) r_mem[r_wptr] <= DAT_I;
  end
  // Strobe edge detect, FIFO pointers/level and the one-cycle accept/drop pulses.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_stb_last <= 1'b0;
      r_ack <= 1'b0;
      r_ovf <= 1'b0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_level <= '0;
    end else begin
      r_stb_last <= STB_I;
      r_ack <= w_push;
      r_ovf <= w_edge & w_full;
      r_wptr <= r_wptr + FIFO_AW'(w_push);
      r_rptr <= r_rptr + FIFO_AW'(w_pop);
      r_level <= r_level + (FIFO_AW+1)'(w_push) - (FIFO_AW+1)'(w_pop);
    end
  end
  // Player state register.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) r_state <= IDLE;
    else r_state <= w_next;
  end
  // Next state: only a finished mask with a newer one queued leaves PLAY.
  always_comb begin
    w_next = PLAY;
    w_next = (r_state == IDLE) ? (w_has ? LOAD : IDLE) :
             (r_state == LOAD) ? PLAY :
             (w_tick && w_last && w_has) ? LOAD : PLAY;
  end
  // Bit timer and shifter; the held copy lets a mask repeat without a gap.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_shreg <= '0;
      r_held <= '0;
      r_bitcnt <= '0;
      r_timer <= '0;
    end else if (r_state == LOAD) begin
      r_shreg <= r_mem[r_rptr];
      r_held <= r_mem[r_rptr];
      r_bitcnt <= '0;
      r_timer <= '0;
    end else if (r_state == PLAY) begin
      r_timer <= r_timer + 1'b1;
      if (w_tick) begin
        r_shreg <= w_last ? r_held : {r_shreg[6:0], 1'b0};
        r_bitcnt <= w_last ? 3'd0 : r_bitcnt + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_prewish_mask_player.sv
// tb_prewish_mask_player: directed checks of strobe accept, FIFO fill/overflow and LED playback
module tb_prewish_mask_player;
  logic CLK_I, RST_I, STB_I;
  logic [7:0] DAT_I;
  logic ACK_O, o_ovf, o_busy, o_led, o_alive;
  logic [2:0] o_level;
  int n_vec, n_err;
  logic [7:0] m;
  logic [7:0] ms [6];
  int cnt, cnt2, mx;

  prewish_mask_player #(.SYSCLK_DIV_BITS(3), .FIFO_AW(2)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .STB_I(STB_I), .DAT_I(DAT_I), .ACK_O(ACK_O),
    .o_ovf(o_ovf), .o_level(o_level), .o_busy(o_busy), .o_led(o_led), .o_alive(o_alive)
  );

  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    STB_I = 1'b0;
    DAT_I = 8'h00;
    RST_I = 1'b0;
    repeat (2) @(negedge CLK_I);
    chk("rst_outputs", {ACK_O, o_ovf, o_level, o_busy, o_led, o_alive}, 8'h00);
    RST_I = 1'b1;
    @(negedge CLK_I);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    // 1: single strobe of A0, pattern repeats seamlessly
    do_reset();
    m = 8'hA0;
    STB_I = 1'b1; DAT_I = m;
    for (int k = 0; k < 140; k++) begin
      @(negedge CLK_I);
      if (k == 0) begin
        STB_I = 1'b0;
        chk("t1_ack", ACK_O, 1);
        chk("t1_level", o_level, 1);
        chk("t1_busy_idle", o_busy, 0);
      end
      if (k == 1) begin
        chk("t1_ack_low", ACK_O, 0);
        chk("t1_load_busy", o_busy, 1);
        chk("t1_load_led", o_led, 0);
      end
      if (k == 2) chk("t1_level_pop", o_level, 0);
      if (k == 5) chk("t1_alive_lo", o_alive, 0);
      if (k == 6) chk("t1_alive_hi", o_alive, 1);
      if (k >= 2) chk("t1_led", o_led, m[7 - ((k - 2) / 8) % 8]);
    end
    // 2: long strobe yields one accept only
    do_reset();
    m = 8'h80;
    STB_I = 1'b1; DAT_I = m;
    cnt = 0; cnt2 = 0; mx = 0;
    for (int k = 0; k < 70; k++) begin
      @(negedge CLK_I);
      if (k == 4) STB_I = 1'b0;
      cnt += ACK_O;
      if (int'(o_level) > mx) mx = int'(o_level);
      if (k >= 2 && k < 66) cnt2 += o_led;
      if (k == 66) chk("t2_repeat", o_led, 1);
    end
    chk("t2_ack_count", cnt, 1);
    chk("t2_level_peak", mx, 1);
    chk("t2_led_high_clks", cnt2, 8);
    // 3: fill FIFO, overflow on sixth strobe, masks 2-5 play in order
    do_reset();
    ms[0] = 8'h11; ms[1] = 8'hC3; ms[2] = 8'h5A; ms[3] = 8'hA5; ms[4] = 8'h3C; ms[5] = 8'hFF;
    STB_I = 1'b1; DAT_I = ms[0];
    cnt = 0; cnt2 = 0;
    for (int k = 0; k < 330; k++) begin
      @(negedge CLK_I);
      cnt += ACK_O;
      cnt2 += o_ovf;
      if (k == 12) chk("t3_level_full", o_level, 4);
      if (k == 15) begin
        chk("t3_ovf", o_ovf, 1);
        chk("t3_no_ack", ACK_O, 0);
        chk("t3_level_kept", o_level, 4);
      end
      if (k == 16) chk("t3_ovf_pulse", o_ovf, 0);
      for (int j = 0; j < 4; j++) begin
        if (k == 66 + 65 * j) begin
          chk("t3_load_dark", o_led, 0);
          chk("t3_load_busy", o_busy, 1);
        end
        if (k == 67 + 65 * j) chk("t3_level_drain", o_level, 3 - j);
        if (k >= 67 + 65 * j && k < 131 + 65 * j && (k - 67 - 65 * j) % 8 == 4) begin
          m = ms[j + 1];
          chk("t3_bit", o_led, m[7 - (k - 67 - 65 * j) / 8]);
        end
      end
      if (k % 3 == 0) STB_I = 1'b0;
      if ((k + 1) % 3 == 0 && (k + 1) / 3 < 6) begin
        STB_I = 1'b1;
        DAT_I = ms[(k + 1) / 3];
      end
    end
    chk("t3_ack_count", cnt, 5);
    chk("t3_ovf_count", cnt2, 1);
    // 4: FF then 81, one dark LOAD clock between them, 81 repeats
    do_reset();
    m = 8'h81;
    STB_I = 1'b1; DAT_I = 8'hFF;
    cnt = 0;
    for (int k = 0; k < 141; k++) begin
      @(negedge CLK_I);
      if (k == 0) STB_I = 1'b0;
      if (k == 2) begin STB_I = 1'b1; DAT_I = m; end
      if (k == 3) STB_I = 1'b0;
      if (k == 1) chk("t4_load1", o_led, 0);
      if (k >= 2 && k < 66) cnt += o_led;
      if (k == 66) chk("t4_load2", o_led, 0);
      if (k >= 67) chk("t4_81", o_led, m[7 - ((k - 67) / 8) % 8]);
    end
    chk("t4_ff_high_clks", cnt, 64);
    // 5: asynchronous reset mid-play, then a normal accept
    do_reset();
    STB_I = 1'b1; DAT_I = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      @(negedge CLK_I);
      if (k % 3 == 0) STB_I = 1'b0;
      if (k == 2) begin STB_I = 1'b1; DAT_I = 8'h11; end
      if (k == 5) begin STB_I = 1'b1; DAT_I = 8'h22; end
      if (k == 6) chk("t5_level2", o_level, 2);
    end
    chk("t5_led_before", o_led, 1);
    #2 RST_I = 1'b0;
    #1;
    chk("t5_async_led", o_led, 0);
    chk("t5_async_busy", o_busy, 0);
    chk("t5_async_level", o_level, 0);
    repeat (2) @(negedge CLK_I);
    RST_I = 1'b1;
    @(negedge CLK_I);
    STB_I = 1'b1; DAT_I = 8'h40;
    for (int k = 0; k < 13; k++) begin
      @(negedge CLK_I);
      if (k == 0) begin
        STB_I = 1'b0;
        chk("t5_ack", ACK_O, 1);
        chk("t5_level1", o_level, 1);
      end
      if (k == 5) chk("t5_bit7", o_led, 0);
      if (k == 12) chk("t5_bit6", o_led, 1);
    end
    // 6: dark mask keeps busy, C0 takes over at mask boundary
    do_reset();
    m = 8'hC0;
    STB_I = 1'b1; DAT_I = 8'h00;
    cnt = 0;
    for (int k = 0; k < 84; k++) begin
      @(negedge CLK_I);
      if (k == 0) begin STB_I = 1'b0; chk("t6_ack", ACK_O, 1); end
      if (k == 5) chk("t6_busy", o_busy, 1);
      if (k == 19) begin STB_I = 1'b1; DAT_I = m; end
      if (k == 20) begin
        STB_I = 1'b0;
        chk("t6_ack2", ACK_O, 1);
        chk("t6_level", o_level, 1);
      end
      if (k < 67) cnt += o_led;
      if (k == 66) chk("t6_load_busy", o_busy, 1);
      if (k == 67) begin
        chk("t6_level0", o_level, 0);
        chk("t6_c0_b7", o_led, m[7]);
      end
      if (k == 75) chk("t6_c0_b6", o_led, m[6]);
      if (k == 83) chk("t6_c0_b5", o_led, m[5]);
    end
    chk("t6_dark_clks", cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
